simon_core_arbiter: RTL
=======================

// Module: simon_core_arbiter
// PURPOSE
//  Shares one simon_top crypto core between NREQ requesters (req 0 = RAS spill/fill engine,
//  others e.g. MMIO crypto, page-encrypt). Round-robin grant, one block in flight at a time.
//  Owns the core's valid/ready handshakes and routes each ciphertext back to its owner.
//  Sits between the requesters and simon_top; the key stays on simon_top and is not routed here.
// PARAMETERS
//  W      32  Simon word width; one block = 2 words.
//  NREQ   2   Number of requesters (>=2).
//  LAT_W  16  Width of the core-latency counter.
// PORTS
//  clk            in   1          Core clock; the only clock.
//  rst_n          in   1          Synchronous reset, active-low (same net drives simon_top arst_n).
//  req_valid      in   NREQ       Requester has a block; held until accepted.
//  req_ready      out  NREQ       One-hot accept strobe.
//  req_mode       in   NREQ       Per requester: 0 = encrypt, 1 = decrypt.
//  req_pt         in   NREQx2xW   Per-requester input block.
//  resp_valid     out  NREQ       One-hot result valid (owner only).
//  resp_ready     in   NREQ       Requester takes the result.
//  resp_ct        out  2xW        Result block (broadcast; qualified by resp_valid).
//  core_valid_i   out  1          To simon_top valid_i.
//  core_ready_o   in   1          From simon_top ready_o.
//  core_mode_i    out  1          To simon_top mode_i.
//  core_pt_i      out  2xW        To simon_top pt_i.
//  core_valid_o   in   1          From simon_top valid_o.
//  core_ready_i   out  1          To simon_top ready_i.
//  core_ct_o      in   2xW        From simon_top ct_o.
//  busy           out  1          State != IDLE.
//  owner          out  $clog2(NREQ)  Current/last grantee.
//  last_lat       out  LAT_W      Cycles spent in WAIT for the last block (saturating).
//  err_spurious   out  1          Sticky: core_valid_o seen outside WAIT.
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, owner=0, last_lat=0, err_spurious=0.
//   All strobes (req_ready, resp_valid, core_valid_i, core_ready_i) are 0. pt/ct regs are cleared.
//   A reset mid-operation abandons the block; no response is ever produced for it.
//  FSM states: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
//  IDLE:
//   - If any req_valid: g = first set bit at or after rr_ptr (wrapping).
//   - req_ready[g]=1 combinationally this cycle.
//   - Latch req_pt[g] and req_mode[g]; owner<=g; go to ISSUE.
//  ISSUE: core_valid_i=1 with the latched pt/mode. On core_ready_o go to WAIT; the lat counter clears to 0.
//  WAIT:
//   - The lat counter increments each cycle and saturates at all-ones.
//   - On core_valid_o: core_ready_i=1 this same cycle, latch core_ct_o, last_lat<=counter, go to DELIVER.
//  DELIVER:
//   - resp_valid[owner]=1; resp_ct holds the latched block.
//   - On resp_ready[owner]: rr_ptr<=(owner+1)%NREQ, go to IDLE.
//   - Back-pressure holds indefinitely and the core stays idle.
//  Latency: accept -> core_valid_i in 1 cycle; core_valid_o -> resp_valid in 1 cycle.
//   A new accept can happen on the cycle after the resp handshake.
//  core_valid_o outside WAIT: err_spurious<=1 (sticky until reset). core_ready_i stays 0. No state change.
//  resp_ready/req_valid from non-owners are ignored outside their own handshake.
//  NREQ not a power of 2: the rr_ptr wrap uses an explicit compare, not a bit truncation.
// CONFIGURATION
//  ARB_PRIO0_EN defined:
//   - In IDLE, requester 0 (RAS) wins whenever req_valid[0]=1, regardless of rr_ptr.
//   - Otherwise round-robin as above. The rr_ptr update is unchanged.
//  ARB_PRIO0_EN undefined: pure round-robin.
// STRUCTURE
//  Package simon_arb_pkg: arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DELIVER};
//   MODE_ENC=1'b0, MODE_DEC=1'b1.
//  Sub-module simon_arb_rr: combinational one-hot grant from (req_valid, rr_ptr) with wrap;
//   honours ARB_PRIO0_EN.
//  Top holds the FSM, data latches, latency counter and error flag.
// TESTING
//  1. Single request: req0 enc pt={32'h1,32'h2}, core model 10-cycle latency
//     -> resp_valid[0] one cycle after core_valid_o, resp_ct==model output, last_lat==10.
//  2. Both valid continuously for 4 blocks (no PRIO) -> grant order 0,1,0,1; busy drops only between blocks.
//  3. Same as 2 with ARB_PRIO0_EN -> grant order 0,0,0,0 while req_valid[0]=1; req1 granted after req0 drops.
//  4. resp_ready[1]=0 for 20 cycles -> resp_valid[1] held, core_valid_i=0,
//     req0 not accepted until the resp handshake completes.
//  5. rst_n=0 for 1 cycle while in WAIT -> all outputs at reset values next cycle, no resp_valid for the lost block.
//  6. core_valid_o pulsed in IDLE -> err_spurious=1 and stays 1; core_ready_i=0; next request completes normally.

Source files
------------

// File: rtl/simon_core_arbiter_pkg.sv
// Shared types and helpers for the Simon core arbiter: FSM state encoding,
// cipher mode codes and the non-power-of-2 safe index wrap.
package simon_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DELIVER
  } arb_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Explicit compare keeps the wrap correct when n is not a power of two.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/simon_core_arbiter_if.sv
// Requester-side bus of the Simon core arbiter: block requests in, results out.
// master = requester side, slave = arbiter side.
interface simon_core_arbiter_if #(
  parameter int W    = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            req_mode;
  logic [NREQ-1:0][2*W-1:0]   req_pt;
  logic [NREQ-1:0]            resp_valid;
  logic [NREQ-1:0]            resp_ready;
  logic [2*W-1:0]             resp_ct;

  modport master (
    output req_valid, req_mode, req_pt, resp_ready,
    input  req_ready, resp_valid, resp_ct
  );

  modport slave (
    input  req_valid, req_mode, req_pt, resp_ready,
    output req_ready, resp_valid, resp_ct
  );
endinterface

// File: rtl/simon_arb_rr.sv
// Combinational round-robin grant picker for the Simon core arbiter.
// With ARB_PRIO0_EN defined, requester 0 wins whenever it is valid.
module simon_arb_rr
  import simon_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [OW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [OW-1:0]   grant_idx,
  output logic            grant_any
);

  // Scan distances 0..NREQ-1 from rr_ptr; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && req_valid[j] && (wrap_idx(int'(rr_ptr) + k, NREQ) == j)) begin
          grant_any = 1'b1;
          grant_idx = OW'(j);
        end
      end
    end
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/simon_core_arbiter.sv
// Shares one simon_top core between NREQ requesters, one block in flight,
// routing each result to its owner. Optional macro: ARB_PRIO0_EN (requester 0 priority).
module simon_core_arbiter
  import simon_arb_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int NREQ  = 2,
  parameter  int LAT_W = 16,
  localparam int OW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  simon_core_arbiter_if.slave   bus,
  output logic                  core_valid_i,
  input  logic                  core_ready_o,
  output logic                  core_mode_i,
  output logic [2*W-1:0]        core_pt_i,
  input  logic                  core_valid_o,
  output logic                  core_ready_i,
  input  logic [2*W-1:0]        core_ct_o,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic [LAT_W-1:0]      last_lat,
  output logic                  err_spurious
);

  arb_state_e       state;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    rr_next;
  logic [2*W-1:0]   pt_q;
  logic [2*W-1:0]   ct_q;
  logic             mode_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [NREQ-1:0]  grant;
  logic [OW-1:0]    grant_idx;
  logic             grant_any;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  simon_arb_rr #(.NREQ(NREQ), .OW(OW)) u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign rr_next      = OW'(wrap_idx(int'(owner) + 1, NREQ));
  assign core_valid_i = (state == ARB_ISSUE);
  assign core_pt_i    = pt_q;
  assign core_mode_i  = mode_q;
  assign bus.resp_ct  = ct_q;
  assign busy         = (state != ARB_IDLE);

  // Accept and core-result strobes are same-cycle; masked while reset is asserted.
  always_comb begin
    bus.req_ready  = (rst_n && state == ARB_IDLE) ? grant : '0;
    core_ready_i   = rst_n && (state == ARB_WAIT) && core_valid_o;
    bus.resp_valid = '0;
    if (state == ARB_DELIVER) bus.resp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      last_lat     <= '0;
      err_spurious <= 1'b0;
      pt_q         <= '0;
      ct_q         <= '0;
      mode_q       <= MODE_ENC;
      lat_cnt      <= '0;
    end else begin
      if (core_valid_o && state != ARB_WAIT) err_spurious <= 1'b1;
      case (state)
        ARB_IDLE: if (grant_any) begin
          pt_q   <= bus.req_pt[grant_idx];
          mode_q <= bus.req_mode[grant_idx];
          owner  <= grant_idx;
          state  <= ARB_ISSUE;
        end
        ARB_ISSUE: if (core_ready_o) begin
          lat_cnt <= '0;
          state   <= ARB_WAIT;
        end
        ARB_WAIT: if (core_valid_o) begin
          ct_q     <= core_ct_o;
          last_lat <= lat_cnt;
          state    <= ARB_DELIVER;
        end else begin
          lat_cnt <= sat_inc(lat_cnt);
        end
        ARB_DELIVER: if (bus.resp_ready[owner]) begin
          rr_ptr <= rr_next;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
